// File: rtl/imem_pkg.sv
// Shared types and constants for the programmable instruction memory.
package imem_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 6;

  // Controller states: post-reset zero fill, normal fetch service, program load.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Number of entries addressed by an addr_w-bit address.
  function automatic int unsigned depth_f(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction store array: one synchronous write port and one synchronous
// read port. The array itself is never reset; only the read register is, so
// fetch data comes up as zero.
module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = depth_f(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write port; clear and load share it, selected by the controller.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: updates only on an accepted fetch, otherwise holds.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= {DATA_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_prog.sv
// Programmable instruction memory: fetch port for the core, streaming
// program-load port for the host loader, and an optional post-reset clear.
module imem_prog
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              prog_start,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              prog_err,
  output logic [ADDR_W:0]   prog_count,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   LAST_COUNT  = {1'b0, LAST_ADDR};
  localparam state_e            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              fvalid_q, fvalid_d;
  logic              fready_q, fready_d;
  logic              pready_q, pready_d;
  logic              busy_q, busy_d;

  logic              fetch_accept_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;

  // Fetches are only served in IDLE, so reads never collide with writes.
  assign fetch_accept_s = (state_q == ST_IDLE) && fetch_en;

  // Next-state, pointer and write-port steering for clear and load.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    err_d       = err_q;
    done_d      = 1'b0;
    ram_we_s    = 1'b0;
    ram_waddr_s = wr_ptr_q;
    ram_wdata_s = prog_data;
    case (state_q)
      ST_CLEAR: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = clr_ptr_q;
        ram_wdata_s = {DATA_W{1'b0}};
        clr_ptr_d   = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (prog_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = prog_base;
          count_d  = {(ADDR_W+1){1'b0}};
          err_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (prog_valid) begin
          ram_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (prog_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (count_q == LAST_COUNT) begin
            // Every entry has been written once: stop rather than overwrite.
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
    fvalid_d = fetch_accept_s;
    fready_d = (state_d == ST_IDLE);
    pready_d = (state_d == ST_LOAD);
    busy_d   = (state_d == ST_CLEAR) || (state_d == ST_LOAD);
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      clr_ptr_q <= {ADDR_W{1'b0}};
      wr_ptr_q  <= {ADDR_W{1'b0}};
      count_q   <= {(ADDR_W+1){1'b0}};
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      fvalid_q  <= 1'b0;
      fready_q  <= (RESET_STATE == ST_IDLE);
      pready_q  <= 1'b0;
      busy_q    <= (RESET_STATE == ST_CLEAR);
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      done_q    <= done_d;
      fvalid_q  <= fvalid_d;
      fready_q  <= fready_d;
      pready_q  <= pready_d;
      busy_q    <= busy_d;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (ram_wdata_s),
    .re_i    (fetch_accept_s),
    .raddr_i (fetch_addr),
    .rdata_o (fetch_data)
  );

  assign fetch_ready = fready_q;
  assign fetch_valid = fvalid_q;
  assign prog_ready  = pready_q;
  assign prog_done   = done_q;
  assign prog_err    = err_q;
  assign prog_count  = count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_imem_prog.sv
// Self-checking bench for imem_prog: fetch-vector table, fetch scoreboard,
// and hand-written sequences for load, wrap, gaps, overflow and reset.
module tb_imem_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (clear on reset)
  logic       rst_n, fetch_en, fetch_ready, fetch_valid;
  logic [5:0] fetch_addr, prog_base;
  logic [7:0] fetch_data, prog_data;
  logic       prog_start, prog_valid, prog_last, prog_ready, prog_done, prog_err, busy;
  logic [6:0] prog_count;

  // Second DUT (no clear on reset)
  logic       n_rst_n, n_fetch_en, n_fetch_ready, n_fetch_valid;
  logic [5:0] n_fetch_addr, n_prog_base;
  logic [7:0] n_fetch_data, n_prog_data;
  logic       n_prog_start, n_prog_valid, n_prog_last, n_prog_ready, n_prog_done, n_prog_err, n_busy;
  logic [6:0] n_prog_count;

  imem_prog #(.DATA_W(8), .ADDR_W(6), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .prog_start(prog_start), .prog_base(prog_base), .prog_valid(prog_valid),
    .prog_data(prog_data), .prog_last(prog_last), .prog_ready(prog_ready),
    .prog_done(prog_done), .prog_err(prog_err), .prog_count(prog_count), .busy(busy)
  );

  imem_prog #(.DATA_W(8), .ADDR_W(6), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst_n(n_rst_n),
    .fetch_en(n_fetch_en), .fetch_addr(n_fetch_addr), .fetch_ready(n_fetch_ready),
    .fetch_valid(n_fetch_valid), .fetch_data(n_fetch_data),
    .prog_start(n_prog_start), .prog_base(n_prog_base), .prog_valid(n_prog_valid),
    .prog_data(n_prog_data), .prog_last(n_prog_last), .prog_ready(n_prog_ready),
    .prog_done(n_prog_done), .prog_err(n_prog_err), .prog_count(n_prog_count), .busy(n_busy)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    string      name;
    logic [5:0] addr;
    logic [7:0] exp;
  } fvec_t;
  fvec_t tbl[14];

  logic [7:0] model_mem [64];
  logic [5:0] wptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and retire any expected fetch result.
  task automatic cyc();
    sb_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, "_valid"}, 32'(fetch_valid), 32'd1);
      check({e.name, "_data"}, 32'(fetch_data), 32'(e.exp));
    end else if (fetch_valid !== 1'b0) begin
      check("spurious_fetch_valid", 32'(fetch_valid), 32'd0);
    end
  endtask

  task automatic fetch(input string name, input logic [5:0] a, input logic [7:0] e);
    sb_t s;
    s.name = name;
    s.exp  = e;
    fetch_en   = 1'b1;
    fetch_addr = a;
    sb.push_back(s);
    cyc();
    fetch_en = 1'b0;
  endtask

  task automatic start(input logic [5:0] base);
    prog_start = 1'b1;
    prog_base  = base;
    wptr       = base;
    cyc();
    prog_start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    prog_valid = 1'b1;
    prog_data  = d;
    prog_last  = last;
    model_mem[wptr] = d;
    wptr = wptr + 6'd1;
    cyc();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  // Count busy cycles from reset release; the model becomes all zero.
  task automatic clear_check(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      cyc();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd64);
    check({tag, "_fetch_ready"}, 32'(fetch_ready), 32'd1);
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
  endtask

  task automatic setv(input int i, input string n, input logic [5:0] a, input logic [7:0] e);
    tbl[i].name = n;
    tbl[i].addr = a;
    tbl[i].exp  = e;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached, expected finish earlier");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    setv(0,  "clr_a0",  6'd0,  8'h00);
    setv(1,  "clr_a31", 6'd31, 8'h00);
    setv(2,  "clr_a63", 6'd63, 8'h00);
    setv(3,  "ld_a10",  6'd10, 8'h41);
    setv(4,  "ld_a11",  6'd11, 8'h46);
    setv(5,  "ld_a12",  6'd12, 8'h4B);
    setv(6,  "ld_a13",  6'd13, 8'h4D);
    setv(7,  "ld_a14",  6'd14, 8'h00);
    setv(8,  "wrap_a62", 6'd62, 8'hA1);
    setv(9,  "wrap_a63", 6'd63, 8'hA2);
    setv(10, "wrap_a0", 6'd0,  8'hA3);
    setv(11, "wrap_a1", 6'd1,  8'hA4);
    setv(12, "wrap_a2", 6'd2,  8'h00);
    setv(13, "wrap_a61", 6'd61, 8'h00);

    rst_n = 1'b0; fetch_en = 1'b0; fetch_addr = 6'd0; prog_start = 1'b0; prog_base = 6'd0;
    prog_valid = 1'b0; prog_data = 8'h00; prog_last = 1'b0; wptr = 6'd0;
    n_rst_n = 1'b0; n_fetch_en = 1'b0; n_fetch_addr = 6'd0; n_prog_start = 1'b0; n_prog_base = 6'd0;
    n_prog_valid = 1'b0; n_prog_data = 8'h00; n_prog_last = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;

    // Reset state
    repeat (3) cyc();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    check("rst_prog_ready", 32'(prog_ready), 32'd0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_data", 32'(fetch_data), 32'd0);
    check("rst_prog_done", 32'(prog_done), 32'd0);
    check("rst_prog_err", 32'(prog_err), 32'd0);
    check("rst_prog_count", 32'(prog_count), 32'd0);
    check("nc_rst_fetch_ready", 32'(n_fetch_ready), 32'd1);
    check("nc_rst_busy", 32'(n_busy), 32'd0);

    // Post-reset clear, then fetches of cleared words
    rst_n = 1'b1;
    n_rst_n = 1'b1;
    clear_check("clear");
    for (int i = 0; i < 3; i++) fetch(tbl[i].name, tbl[i].addr, tbl[i].exp);

    // Basic load
    start(6'd10);
    check("ld_prog_ready", 32'(prog_ready), 32'd1);
    check("ld_busy", 32'(busy), 32'd1);
    check("ld_fetch_ready", 32'(fetch_ready), 32'd0);
    beat(8'h41, 1'b0);
    beat(8'h46, 1'b0);
    beat(8'h4B, 1'b0);
    check("ld_no_early_done", 32'(prog_done), 32'd0);
    beat(8'h4D, 1'b1);
    check("ld_done", 32'(prog_done), 32'd1);
    check("ld_count", 32'(prog_count), 32'd4);
    check("ld_err", 32'(prog_err), 32'd0);
    check("ld_idle_ready", 32'(fetch_ready), 32'd1);
    check("ld_idle_busy", 32'(busy), 32'd0);
    cyc();
    check("ld_done_pulse_end", 32'(prog_done), 32'd0);
    check("ld_count_hold", 32'(prog_count), 32'd4);

    // Wrapping load
    start(6'd62);
    beat(8'hA1, 1'b0);
    beat(8'hA2, 1'b0);
    beat(8'hA3, 1'b0);
    beat(8'hA4, 1'b1);
    check("wrap_done", 32'(prog_done), 32'd1);
    check("wrap_count", 32'(prog_count), 32'd4);
    for (int i = 3; i < 14; i++) fetch(tbl[i].name, tbl[i].addr, tbl[i].exp);

    // Fetch data holds when no fetch is accepted
    fetch("hold_src", 6'd12, 8'h4B);
    cyc();
    check("hold_valid", 32'(fetch_valid), 32'd0);
    check("hold_data", 32'(fetch_data), 32'h4B);

    // prog_start together with a fetch, then gaps and fetch lockout
    fetch_en = 1'b1;
    fetch_addr = 6'd10;
    sb.push_back('{"start_fetch", 8'h41});
    prog_start = 1'b1;
    prog_base = 6'd20;
    wptr = 6'd20;
    cyc();
    prog_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      prog_valid = (k == 0 || k == 3);
      prog_data  = (k == 0) ? 8'h11 : ((k == 3) ? 8'h22 : 8'hFF);
      prog_last  = (k != 0);
      prog_start = (k == 1);
      prog_base  = 6'd40;
      if (prog_valid) begin
        model_mem[wptr] = prog_data;
        wptr = wptr + 6'd1;
      end
      cyc();
      if (k < 3) begin
        check("lock_fetch_ready", 32'(fetch_ready), 32'd0);
        check("lock_fetch_valid", 32'(fetch_valid), 32'd0);
        check("lock_prog_ready", 32'(prog_ready), 32'd1);
      end
    end
    prog_valid = 1'b0; prog_last = 1'b0; prog_start = 1'b0; fetch_en = 1'b0;
    check("gap_done", 32'(prog_done), 32'd1);
    check("gap_count", 32'(prog_count), 32'd2);
    fetch("gap_a20", 6'd20, model_mem[20]);
    fetch("gap_a21", 6'd21, model_mem[21]);
    fetch("gap_a22", 6'd22, model_mem[22]);

    // Overflow: 64 beats without last
    start(6'd5);
    for (int i = 0; i < 64; i++) begin
      beat(8'(i), 1'b0);
      if (i == 62) begin
        check("ovf_err_before", 32'(prog_err), 32'd0);
        check("ovf_still_load", 32'(prog_ready), 32'd1);
      end
    end
    check("ovf_err", 32'(prog_err), 32'd1);
    check("ovf_count", 32'(prog_count), 32'd64);
    check("ovf_done", 32'(prog_done), 32'd1);
    check("ovf_idle", 32'(fetch_ready), 32'd1);
    check("ovf_prog_ready", 32'(prog_ready), 32'd0);
    cyc();
    check("ovf_done_end", 32'(prog_done), 32'd0);
    check("ovf_err_sticky", 32'(prog_err), 32'd1);
    fetch("ovf_a4", 6'd4, 8'd63);
    fetch("ovf_a5", 6'd5, 8'd0);
    fetch("ovf_a6", 6'd6, model_mem[6]);
    start(6'd0);
    check("restart_err_clr", 32'(prog_err), 32'd0);
    check("restart_count_clr", 32'(prog_count), 32'd0);
    beat(8'h77, 1'b1);
    check("restart_count", 32'(prog_count), 32'd1);
    fetch("restart_a0", 6'd0, model_mem[0]);

    // Reset in the middle of a load
    start(6'd30);
    beat(8'h55, 1'b0);
    beat(8'h66, 1'b0);
    rst_n = 1'b0;
    cyc();
    check("midrst_no_done", 32'(prog_done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_count", 32'(prog_count), 32'd0);
    check("midrst_prog_ready", 32'(prog_ready), 32'd0);
    cyc();
    rst_n = 1'b1;
    clear_check("reclear");
    for (int a = 0; a < 64; a++) fetch("reclear_word", 6'(a), model_mem[a]);

    // No-clear variant: contents survive a reset in the middle of a load
    n_rst_n = 1'b0;
    cyc();
    check("nc_fetch_ready_after_rst", 32'(n_fetch_ready), 32'd1);
    check("nc_busy_after_rst", 32'(n_busy), 32'd0);
    n_rst_n = 1'b1;
    n_prog_start = 1'b1;
    n_prog_base = 6'd7;
    cyc();
    n_prog_start = 1'b0;
    check("nc_prog_ready", 32'(n_prog_ready), 32'd1);
    n_prog_valid = 1'b1;
    n_prog_data = 8'h5A;
    cyc();
    n_prog_data = 8'hC3;
    cyc();
    n_prog_valid = 1'b0;
    n_rst_n = 1'b0;
    cyc();
    check("nc_midrst_no_done", 32'(n_prog_done), 32'd0);
    check("nc_midrst_ready", 32'(n_fetch_ready), 32'd1);
    check("nc_midrst_count", 32'(n_prog_count), 32'd0);
    check("nc_midrst_err", 32'(n_prog_err), 32'd0);
    n_rst_n = 1'b1;
    n_fetch_en = 1'b1;
    n_fetch_addr = 6'd7;
    cyc();
    check("nc_a7_valid", 32'(n_fetch_valid), 32'd1);
    check("nc_a7_data", 32'(n_fetch_data), 32'h5A);
    n_fetch_addr = 6'd8;
    cyc();
    check("nc_a8_valid", 32'(n_fetch_valid), 32'd1);
    check("nc_a8_data", 32'(n_fetch_data), 32'hC3);
    n_fetch_en = 1'b0;
    cyc();
    check("nc_hold_valid", 32'(n_fetch_valid), 32'd0);
    check("nc_hold_data", 32'(n_fetch_data), 32'hC3);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
